// File: rtl/apb_ram_pkg.sv
// Shared FSM state type and address-decode helpers for the wide APB RAM.
// Width helpers take the instance parameters so each instance derives its own sizes.
package apb_ram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Widest paddr the decode helper accepts.
  localparam int ADDR_MAX_W = 64;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lsb_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // High when the byte address is not word aligned or its word lies past the last one.
  function automatic logic addr_err(input logic [ADDR_MAX_W-1:0] paddr,
                                    input int lsb,
                                    input int depth);
    logic [ADDR_MAX_W-1:0] mask;
    logic [ADDR_MAX_W-1:0] index;
    mask  = (64'd1 << lsb) - 64'd1;
    index = paddr >> lsb;
    return ((paddr & mask) != '0) || (index >= ADDR_MAX_W'(unsigned'(depth)));
  endfunction

endpackage

// File: rtl/apb_ram_wide_mem.sv
// DEPTH x DATA_W word store: byte-lane synchronous write, combinational read,
// whole array cleared while presetn is low.
module apb_ram_wide_mem
  import apb_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_waddr,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [IDX_W-1:0]    i_raddr,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int STRB_W = strb_w(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int w = 0; w < DEPTH; w++) begin
        r_mem[w] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Indices past DEPTH exist when DEPTH is not a power of two; they read as zero.
  assign o_rdata = (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/apb_ram_wide.sv
// APB4 completer RAM with configurable width, depth and wait states.
// Holds the transfer FSM, wait counter, address decode and registered outputs.
module apb_ram_wide
  import apb_ram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int         LSB   = lsb_of(DATA_W);
  localparam int         IDX_W = idx_w(DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_err;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_prdata;
  logic              r_pready;
  logic              r_pslverr;

  logic              w_err_live;
  logic [IDX_W-1:0]  w_idx_live;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_cur_err;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_rd_next;
  logic              w_we;

  assign w_err_live = addr_err(ADDR_MAX_W'(paddr), LSB, DEPTH);
  assign w_idx_live = IDX_W'(paddr >> LSB);

  // With no wait states pready rises on the setup edge, so decode must use the live address.
  assign w_rd_idx  = (r_state == IDLE) ? w_idx_live : r_idx;
  assign w_cur_err = (r_state == IDLE) ? w_err_live : r_err;
  assign w_rd_next = (!pwrite && !w_cur_err) ? w_rdata : '0;
  assign w_we      = (r_state == ACCESS) && psel && penable && pwrite && !r_err;

  apb_ram_wide_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .pclk    (pclk),
    .presetn (presetn),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wstrb (pstrb),
    .i_wdata (pwdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (psel && !penable) begin
            r_err <= w_err_live;
            r_idx <= w_idx_live;
            if (WAIT_STATES == 0) begin
              r_state   <= ACCESS;
              r_pready  <= 1'b1;
              r_pslverr <= w_err_live;
              r_prdata  <= w_rd_next;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WS;
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end else if (penable) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state   <= ACCESS;
              r_pready  <= 1'b1;
              r_pslverr <= r_err;
              r_prdata  <= w_rd_next;
            end
          end
        end
        ACCESS: begin
          // Completion and abort both end here; only completion enables the write.
          if (!psel || penable) begin
            r_state   <= IDLE;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_prdata  <= '0;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end
      endcase
    end
  end

  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;

endmodule
